vgafb_scanout: RTL and testbench
================================

Name: vgafb_scanout

Overview:
- Pixel-domain scan-out stage, directly downstream of the vgafb asynchronous FIFO read port.
- Generates programmable horizontal/vertical timing and pops one RGB565 word per active pixel from the FIFO's first-word-fall-through output.
- Drives registered RGB, sync and blank signals to the video DAC.
- Blanks the pixel and flags underflow when the FIFO runs dry during the active area.

Parameters:
- TW, 11, width of all timing counters and timing config inputs.
- PW, 16, pixel width (RGB565: [15:11] R, [10:5] G, [4:0] B).

Ports:
- vga_clk  in  1  pixel clock
- vga_rst_n  in  1  asynchronous, active-low reset
- enable  in  1  scan-out enable (static config domain)
- hres, hsync_start, hsync_end, hscan  in  TW each  horizontal timing (last column index = hscan)
- vres, vsync_start, vsync_end, vscan  in  TW each  vertical timing (last line index = vscan)
- fifo_data  in  PW  FIFO head word (valid whenever fifo_empty=0)
- fifo_empty  in  1  FIFO empty flag
- fifo_re  out  1  FIFO read enable (pop)
- vga_r, vga_g, vga_b  out  5/6/5  registered pixel colour
- vga_hsync_n, vga_vsync_n  out  1 each  active-low syncs
- vga_blank_n  out  1  high during active pixels
- frame_start  out  1  one-cycle pulse aligned with output of pixel (0,0)
- underflow  out  1  sticky underflow flag

Behaviour:
- Clock/reset: one clock domain; vga_rst_n is asynchronous, active-low.
- Reset values:
  - hcount=0, vcount=0, run=0, shadow config=0.
  - vga_r/g/b=0, vga_hsync_n=1, vga_vsync_n=1, vga_blank_n=0, frame_start=0, underflow=0.
  - fifo_re=0 (follows from run=0).
- Run control:
  - run <= enable each cycle.
  - On a run 0->1 transition, all eight timing inputs are latched into shadow registers and counters start from (0,0).
  - While run=0: counters are held at 0, fifo_re=0, outputs are forced to their reset values, underflow is cleared.
- Counters:
  - hcount increments every cycle while run=1; at hcount==hscan_s it wraps to 0 and vcount increments.
  - At vcount==vscan_s together with hcount==hscan_s, both counters wrap to 0 and the shadow registers reload from the inputs. Config therefore changes only on frame boundaries.
- Stage-0 decode (combinational from the counters):
  - active = run & (hcount < hres_s) & (vcount < vres_s)
  - hs = hsync_start_s <= hcount < hsync_end_s
  - vs = vsync_start_s <= vcount < vsync_end_s
  - all comparisons unsigned, TW bits.
- FIFO handshake: fifo_re = active & ~fifo_empty, combinational, same cycle. The FIFO head is consumed on the same vga_clk edge that registers it.
- Output stage: one register stage, so latency is 1 cycle from counter value to pins.
  - vga_blank_n <= active.
  - {r,g,b} <= (active & ~fifo_empty) ? fifo_data : 0.
  - vga_hsync_n <= ~(run & hs); vga_vsync_n <= ~(run & vs).
  - frame_start <= run & (hcount==0) & (vcount==0).
- Underflow:
  - Condition: active & fifo_empty.
  - Effect: that pixel outputs black, no pop, and the underflow flag sets.
  - The flag stays set until run=0.
  - The counters never stall; timing is never disturbed by FIFO state.
- Boundary rules:
  - hres_s=0 or vres_s=0: no active pixels, no pops; syncs still generated.
  - hsync_end_s <= hsync_start_s: hsync never asserted (same for vertical).
  - Reset asserted mid-line: all outputs return to reset values asynchronously.
  - enable deasserted mid-frame: stop on the next edge; no partial-frame resume. Re-enable restarts at (0,0).

Optional Feature:
- Macro: VGAFB_SCANOUT_UFCNT_EN.
- Defined: adds output underflow_count[15:0].
  - Increments once per underflowed pixel, saturating at 16'hFFFF.
  - Cleared by reset and while run=0.
- Undefined: port and counter are absent; the sticky underflow flag is unchanged.

Test Plan:
- Common timing: hres=4, hsync_start=5, hsync_end=6, hscan=7, vres=2, vsync_start=3, vsync_end=4, vscan=5, FIFO model always non-empty, enable=1.
- Basic timing: common timing, fifo_data=incrementing from 0 -> fifo_re high 4 of every 8 cycles on lines 0-1; blank_n high 4 cycles/line; hsync_n low exactly 1 cycle/line (pixel period 5); vsync_n low for 8 cycles (line 3); frame_start period 48 cycles; first pixel out = 0x0000, one cycle after first fifo_re.
- Underflow: common timing, fifo_empty=1 during pixel (2,0) only -> that pixel RGB=0, blank_n=1, no pop there, underflow=1 and held; later pixels resume from the un-popped word. With VGAFB_SCANOUT_UFCNT_EN, underflow_count=1.
- Frame-boundary reload: change hres to 2 mid-frame -> current frame keeps 4 active/line; next frame after frame_start has 2.
- Enable drop: deassert enable at line 1 column 2 -> next edge: fifo_re=0, blank_n=0, both syncs high, underflow cleared. Re-enable -> frame_start two cycles later (cycle 1: run rises; cycle 2: registered pulse at (0,0)).
- Async reset: pulse vga_rst_n low between clock edges mid-active -> outputs take reset values immediately, without a clock edge. Counters restart at (0,0) after release and enable.
- Degenerate config: hres=0 -> fifo_re never asserts over 2 frames; syncs still toggle on schedule.

Source files
------------

// File: rtl/vgafb_scanout.sv
// vgafb_scanout: pixel-domain scan-out stage for the vgafb frame buffer.
// Counts programmable H/V timing and pops one RGB565 word per active pixel
// from the first-word-fall-through FIFO head. RGB, syncs, blank and
// frame_start go to the DAC through one register stage.
// When the FIFO is empty during an active pixel, that pixel is shown
// black and a sticky underflow flag is set.
// Optional: define VGAFB_SCANOUT_UFCNT_EN to add a saturating 16-bit
// underflow_count output.
module vgafb_scanout #(
  parameter int TW = 11,
  parameter int PW = 16
) (
  input  logic          vga_clk,
  input  logic          vga_rst_n,
  input  logic          enable,
  input  logic [TW-1:0] hres,
  input  logic [TW-1:0] hsync_start,
  input  logic [TW-1:0] hsync_end,
  input  logic [TW-1:0] hscan,
  input  logic [TW-1:0] vres,
  input  logic [TW-1:0] vsync_start,
  input  logic [TW-1:0] vsync_end,
  input  logic [TW-1:0] vscan,
  input  logic [PW-1:0] fifo_data,
  input  logic          fifo_empty,
  output logic          fifo_re,
  output logic [4:0]    vga_r,
  output logic [5:0]    vga_g,
  output logic [4:0]    vga_b,
  output logic          vga_hsync_n,
  output logic          vga_vsync_n,
  output logic          vga_blank_n,
  output logic          frame_start,
  output logic          underflow
`ifdef VGAFB_SCANOUT_UFCNT_EN
  ,
  output logic [15:0]   underflow_count
`endif
);

  typedef struct packed {
    logic [TW-1:0] hres;
    logic [TW-1:0] hsync_start;
    logic [TW-1:0] hsync_end;
    logic [TW-1:0] hscan;
    logic [TW-1:0] vres;
    logic [TW-1:0] vsync_start;
    logic [TW-1:0] vsync_end;
    logic [TW-1:0] vscan;
  } timing_t;

  timing_t       cfg_in;
  timing_t       cfg_q, cfg_d;
  logic          run_q;
  logic [TW-1:0] hcount_q, hcount_d;
  logic [TW-1:0] vcount_q, vcount_d;

  logic [PW-1:0] rgb_q, rgb_d;
  logic          blank_n_q, blank_n_d;
  logic          hsync_n_q, hsync_n_d;
  logic          vsync_n_q, vsync_n_d;
  logic          frame_start_q, frame_start_d;
  logic          underflow_q, underflow_d;
`ifdef VGAFB_SCANOUT_UFCNT_EN
  logic [15:0]   ufcnt_q, ufcnt_d;
`endif

  logic h_last, v_last;
  logic active, hs, vs, pop, uf;

  assign cfg_in = '{hres:        hres,
                    hsync_start: hsync_start,
                    hsync_end:   hsync_end,
                    hscan:       hscan,
                    vres:        vres,
                    vsync_start: vsync_start,
                    vsync_end:   vsync_end,
                    vscan:       vscan};

  // Stage-0 decode straight from the counters and the shadow timing.
  assign h_last = (hcount_q == cfg_q.hscan);
  assign v_last = (vcount_q == cfg_q.vscan);
  assign active = run_q & (hcount_q < cfg_q.hres) & (vcount_q < cfg_q.vres);
  assign hs     = (hcount_q >= cfg_q.hsync_start) & (hcount_q < cfg_q.hsync_end);
  assign vs     = (vcount_q >= cfg_q.vsync_start) & (vcount_q < cfg_q.vsync_end);
  assign pop    = active & ~fifo_empty;
  assign uf     = active & fifo_empty;

  // The head word is consumed on the same edge that registers it below.
  assign fifo_re = pop;

  // Counter and shadow-config next state; enable low stops on the next edge.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    cfg_d    = cfg_q;
    if (!enable) begin
      hcount_d = '0;
      vcount_d = '0;
    end else if (!run_q) begin
      // Starting up: capture timing and begin from (0,0).
      hcount_d = '0;
      vcount_d = '0;
      cfg_d    = cfg_in;
    end else if (h_last) begin
      hcount_d = '0;
      if (v_last) begin
        // Frame boundary: the only point where new timing takes effect.
        vcount_d = '0;
        cfg_d    = cfg_in;
      end else begin
        vcount_d = vcount_q + TW'(1);
      end
    end else begin
      hcount_d = hcount_q + TW'(1);
    end
  end

  // Output-stage next state; forced to idle values whenever the run stops.
  always_comb begin
    rgb_d         = '0;
    blank_n_d     = 1'b0;
    hsync_n_d     = 1'b1;
    vsync_n_d     = 1'b1;
    frame_start_d = 1'b0;
    underflow_d   = 1'b0;
`ifdef VGAFB_SCANOUT_UFCNT_EN
    ufcnt_d       = '0;
`endif
    if (enable) begin
      rgb_d         = pop ? fifo_data : '0;
      blank_n_d     = active;
      hsync_n_d     = ~(run_q & hs);
      vsync_n_d     = ~(run_q & vs);
      frame_start_d = run_q & (hcount_q == '0) & (vcount_q == '0);
      underflow_d   = underflow_q | uf;
`ifdef VGAFB_SCANOUT_UFCNT_EN
      ufcnt_d       = (uf && ufcnt_q != 16'hFFFF) ? ufcnt_q + 16'd1 : ufcnt_q;
`endif
    end
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    // NOTE: no storage arrays here, so every flop takes the async reset and
    // the pins go to their idle values the moment vga_rst_n falls.
    if (!vga_rst_n) begin
      run_q         <= 1'b0;
      cfg_q         <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      rgb_q         <= '0;
      blank_n_q     <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
`ifdef VGAFB_SCANOUT_UFCNT_EN
      ufcnt_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      run_q         <= enable;
      cfg_q         <= cfg_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      rgb_q         <= rgb_d;
      blank_n_q     <= blank_n_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
`ifdef VGAFB_SCANOUT_UFCNT_EN
      ufcnt_q       <= ufcnt_d;
`endif
    end
  end

  assign vga_r       = rgb_q[15:11];
  assign vga_g       = rgb_q[10:5];
  assign vga_b       = rgb_q[4:0];
  assign vga_hsync_n = hsync_n_q;
  assign vga_vsync_n = vsync_n_q;
  assign vga_blank_n = blank_n_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;
`ifdef VGAFB_SCANOUT_UFCNT_EN
  assign underflow_count = ufcnt_q;
`endif

endmodule

// File: tb/tb_vgafb_scanout.sv
// Directed bench for vgafb_scanout with a FIFO model and a pixel scoreboard.
// Honours VGAFB_SCANOUT_UFCNT_EN when the design is built with it.
module tb_vgafb_scanout;
  localparam int TW = 11;
  localparam int PW = 16;

  logic          vga_clk   = 1'b0;
  logic          vga_rst_n = 1'b1;
  logic          enable    = 1'b0;
  logic [TW-1:0] hres = 11'd4, hsync_start = 11'd5, hsync_end = 11'd6, hscan = 11'd7;
  logic [TW-1:0] vres = 11'd2, vsync_start = 11'd3, vsync_end = 11'd4, vscan = 11'd5;
  logic [PW-1:0] fifo_data  = '0;
  logic          fifo_empty = 1'b0;
  logic          fifo_re;
  logic [4:0]    vga_r;
  logic [5:0]    vga_g;
  logic [4:0]    vga_b;
  logic          vga_hsync_n, vga_vsync_n, vga_blank_n, frame_start, underflow;
`ifdef VGAFB_SCANOUT_UFCNT_EN
  logic [15:0]   underflow_count;
`endif

  vgafb_scanout #(.TW(TW), .PW(PW)) dut (
    .vga_clk     (vga_clk),
    .vga_rst_n   (vga_rst_n),
    .enable      (enable),
    .hres        (hres),
    .hsync_start (hsync_start),
    .hsync_end   (hsync_end),
    .hscan       (hscan),
    .vres        (vres),
    .vsync_start (vsync_start),
    .vsync_end   (vsync_end),
    .vscan       (vscan),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .fifo_re     (fifo_re),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hsync_n (vga_hsync_n),
    .vga_vsync_n (vga_vsync_n),
    .vga_blank_n (vga_blank_n),
    .frame_start (frame_start),
    .underflow   (underflow)
`ifdef VGAFB_SCANOUT_UFCNT_EN
    ,
    .underflow_count (underflow_count)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  int n_pass = 0;
  int n_total = 0;

  // FIFO model: head word is a running counter; 16'hDEAD marks an empty head.
  int word = 0;
  logic [PW-1:0] sb[$];

  int cyc = 0;
  int n_re, n_blank, n_hs, n_vs, n_fs;
  int fs_first, fs_last, first_re, first_blank;
  logic [PW-1:0] first_pix;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic refresh_fifo();
    fifo_data = fifo_empty ? 16'hDEAD : word[15:0];
  endtask

  task automatic set_empty(input logic e);
    fifo_empty = e;
    refresh_fifo();
  endtask

  task automatic clear_stats();
    n_re = 0; n_blank = 0; n_hs = 0; n_vs = 0; n_fs = 0;
    fs_first = -1; fs_last = -1; first_re = -1; first_blank = -1;
    first_pix = 'x;
  endtask

  // One pixel clock: sample the pop request mid-cycle, then inspect the
  // registered pins 1 time unit after the rising edge.
  task automatic tick();
    logic          pre_re;
    logic [PW-1:0] pre_dat, exp, rgb;
    @(negedge vga_clk);
    pre_re  = fifo_re;
    pre_dat = fifo_data;
    @(posedge vga_clk);
    #1;
    if (pre_re) begin
      sb.push_back(pre_dat);
      word++;
      n_re++;
      if (first_re < 0) first_re = cyc;
    end
    cyc++;
    refresh_fifo();
    rgb = {vga_r, vga_g, vga_b};
    if (vga_blank_n) begin
      n_blank++;
      exp = (sb.size() > 0) ? sb.pop_front() : 16'h0000;
      check("pixel", 32'(rgb), 32'(exp));
      if (first_blank < 0) begin
        first_blank = cyc;
        first_pix   = rgb;
      end
    end
    if (!vga_hsync_n) n_hs++;
    if (!vga_vsync_n) n_vs++;
    if (frame_start) begin
      n_fs++;
      if (fs_first < 0) fs_first = cyc;
      fs_last = cyc;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clear_stats();
    // Reset values.
    #1 vga_rst_n = 1'b0;
    #1;
    check("rst_blank_n", 32'(vga_blank_n), 32'd0);
    check("rst_hsync_n", 32'(vga_hsync_n), 32'd1);
    check("rst_vsync_n", 32'(vga_vsync_n), 32'd1);
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_fifo_re", 32'(fifo_re), 32'd0);
    ticks(2);
    vga_rst_n = 1'b1;

    // Basic timing over two 8x6 frames.
    enable = 1'b1;
    clear_stats();
    ticks(97);
    check("basic_pops", 32'(n_re), 32'd16);
    check("basic_blank", 32'(n_blank), 32'd16);
    check("basic_hsync", 32'(n_hs), 32'd12);
    check("basic_vsync", 32'(n_vs), 32'd16);
    check("basic_fs_count", 32'(n_fs), 32'd2);
    check("basic_fs_period", 32'(fs_last - fs_first), 32'd48);
    check("basic_first_pix", 32'(first_pix), 32'd0);
    check("basic_first_lat", 32'(first_blank - first_re), 32'd1);
    check("basic_sb_drained", 32'(sb.size()), 32'd0);
    check("basic_no_uf", 32'(underflow), 32'd0);

    // Underflow at pixel (2,0) of the next frame.
    clear_stats();
    ticks(2);
    set_empty(1'b1);
    tick();
    set_empty(1'b0);
    check("uf_blank_n", 32'(vga_blank_n), 32'd1);
    check("uf_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("uf_flag", 32'(underflow), 32'd1);
    ticks(45);
    check("uf_pops", 32'(n_re), 32'd7);
    check("uf_blank", 32'(n_blank), 32'd8);
    check("uf_sticky", 32'(underflow), 32'd1);
`ifdef VGAFB_SCANOUT_UFCNT_EN
    check("uf_count", 32'(underflow_count), 32'd1);
`endif

    // Frame-boundary reload: hres=2 written at line 1 column 2.
    ticks(10);
    hres = 11'd2;
    clear_stats();
    ticks(38);
    check("reload_old_frame", 32'(n_blank), 32'd2);
    clear_stats();
    ticks(48);
    check("reload_new_blank", 32'(n_blank), 32'd4);
    check("reload_new_pops", 32'(n_re), 32'd4);
    check("reload_fs", 32'(n_fs), 32'd1);
    hres = 11'd4;
    ticks(48);

    // Enable drop at line 1 column 2, with underflow set earlier in the frame.
    tick();
    set_empty(1'b1);
    tick();
    set_empty(1'b0);
    ticks(8);
    check("drop_pre_fifo_re", 32'(fifo_re), 32'd1);
    check("drop_pre_uf", 32'(underflow), 32'd1);
    enable = 1'b0;
    tick();
    sb.delete();  // the word popped on the stopping edge is never displayed
    check("drop_fifo_re", 32'(fifo_re), 32'd0);
    check("drop_blank_n", 32'(vga_blank_n), 32'd0);
    check("drop_hsync_n", 32'(vga_hsync_n), 32'd1);
    check("drop_vsync_n", 32'(vga_vsync_n), 32'd1);
    check("drop_uf", 32'(underflow), 32'd0);
    check("drop_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
`ifdef VGAFB_SCANOUT_UFCNT_EN
    check("drop_uf_count", 32'(underflow_count), 32'd0);
`endif
    ticks(3);
    enable = 1'b1;
    tick();
    check("reen_fs_c1", 32'(frame_start), 32'd0);
    tick();
    check("reen_fs_c2", 32'(frame_start), 32'd1);
    check("reen_blank_c2", 32'(vga_blank_n), 32'd1);

    // Async reset between edges while an active pixel is on the pins.
    ticks(2);
    check("arst_pre_blank", 32'(vga_blank_n), 32'd1);
    #2 vga_rst_n = 1'b0;
    #1;
    check("arst_blank_n", 32'(vga_blank_n), 32'd0);
    check("arst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("arst_hsync_n", 32'(vga_hsync_n), 32'd1);
    check("arst_vsync_n", 32'(vga_vsync_n), 32'd1);
    check("arst_fifo_re", 32'(fifo_re), 32'd0);
    sb.delete();
    ticks(2);
    vga_rst_n = 1'b1;
    tick();
    check("arst_fs_c1", 32'(frame_start), 32'd0);
    tick();
    check("arst_fs_c2", 32'(frame_start), 32'd1);
    check("arst_blank_c2", 32'(vga_blank_n), 32'd1);

    // Degenerate config: hres=0 gives no pixels but full sync timing.
    enable = 1'b0;
    tick();
    sb.delete();
    hres   = 11'd0;
    enable = 1'b1;
    clear_stats();
    ticks(97);
    check("degen_pops", 32'(n_re), 32'd0);
    check("degen_blank", 32'(n_blank), 32'd0);
    check("degen_hsync", 32'(n_hs), 32'd12);
    check("degen_vsync", 32'(n_vs), 32'd16);
    check("degen_fs", 32'(n_fs), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
